cp_bypass_ctrl: RTL and testbench

- Hazard and bypass controller for the CP operand bypass network; sits in the CP IF stage beside the decoder.
- Tracks the destination of the instruction currently in ID, i.e. the one that will be in EX when the current IF instruction reaches ID.
- Drives the registered bypass-read flags and source selects consumed by the bypass mux in ID.
- Raises a one-cycle load-use stall when the producer's result is not available in EX, and counts stall events.

---
 rtl/cp_bypass_ctrl.sv | 96 +++++++++
 tb/tb_cp_bypass_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cp_bypass_ctrl.sv
// Load-use hazard and EX bypass controller for the CP operand bypass network.
// Tracks the destination of the instruction in ID and registers bypass flags for the consumer.
module cp_bypass_ctrl #(
  parameter int RF_INDEX_WIDTH = 5,
  parameter bit LOAD_USE_STALL = 1'b1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      iClk,
  input  logic                      iReset_n,
  input  logic                      iIF_Valid,
  input  logic [RF_INDEX_WIDTH-1:0] iIF_RF_Read_Addr_A,
  input  logic                      iIF_Read_A_En,
  input  logic [RF_INDEX_WIDTH-1:0] iIF_RF_Read_Addr_B,
  input  logic                      iIF_Read_B_En,
  input  logic [RF_INDEX_WIDTH-1:0] iIF_Dest_Addr,
  input  logic                      iIF_Dest_En,
  input  logic [1:0]                iIF_Dest_Src,
  input  logic                      iStall,
  input  logic                      iFlush,
  output logic                      oIF_BP_Bypass_Read_A,
  output logic                      oIF_BP_Bypass_Read_B,
  output logic [1:0]                oIF_BP_Bypass_Sel_A,
  output logic [1:0]                oIF_BP_Bypass_Sel_B,
  output logic                      oLoad_Use_Stall,
  output logic [CNT_WIDTH-1:0]      oStall_Count
);

  localparam logic [1:0] SRC_LSU = 2'd2;

  logic                      slot_vld_p1;
  logic [RF_INDEX_WIDTH-1:0] slot_dest_p1;
  logic [1:0]                slot_src_p1;

  logic match_a;
  logic match_b;
  logic hazard;
  logic slot_load_vld;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val);
    if (&val)
      return val;
    return val + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // IF stage: compare the IF sources against the instruction held in ID
  assign match_a = iIF_Valid & iIF_Read_A_En & slot_vld_p1 &
                   (iIF_RF_Read_Addr_A == slot_dest_p1);
  assign match_b = iIF_Valid & iIF_Read_B_En & slot_vld_p1 &
                   (iIF_RF_Read_Addr_B == slot_dest_p1);
  assign hazard  = (match_a | match_b) & (slot_src_p1 == SRC_LSU) & LOAD_USE_STALL;

  // Zero-latency stall so fetch can hold IF in the same cycle; a flush kills the consumer anyway.
  assign oLoad_Use_Stall = hazard & ~iFlush;

  // r0 is hard-wired, so it is never entered into the slot as a valid producer.
  assign slot_load_vld = iIF_Valid & iIF_Dest_En & (iIF_Dest_Addr != '0);

  // ID stage: producer slot, registered bypass controls and stall counter
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      slot_vld_p1          <= 1'b0;
      slot_dest_p1         <= '0;
      slot_src_p1          <= 2'd0;
      oIF_BP_Bypass_Read_A <= 1'b0;
      oIF_BP_Bypass_Read_B <= 1'b0;
      oIF_BP_Bypass_Sel_A  <= 2'd0;
      oIF_BP_Bypass_Sel_B  <= 2'd0;
      oStall_Count         <= '0;
    end else if (iFlush) begin
      slot_vld_p1          <= 1'b0;
      oIF_BP_Bypass_Read_A <= 1'b0;
      oIF_BP_Bypass_Read_B <= 1'b0;
      oIF_BP_Bypass_Sel_A  <= 2'd0;
      oIF_BP_Bypass_Sel_B  <= 2'd0;
    end else if (!iStall) begin
      if (oLoad_Use_Stall) begin
        // Bubble into ID; the replayed consumer picks the load up from WB instead.
        slot_vld_p1          <= 1'b0;
        oIF_BP_Bypass_Read_A <= 1'b0;
        oIF_BP_Bypass_Read_B <= 1'b0;
        oIF_BP_Bypass_Sel_A  <= 2'd0;
        oIF_BP_Bypass_Sel_B  <= 2'd0;
        oStall_Count         <= sat_inc(oStall_Count);
      end else begin
        oIF_BP_Bypass_Read_A <= match_a;
        oIF_BP_Bypass_Read_B <= match_b;
        oIF_BP_Bypass_Sel_A  <= match_a ? slot_src_p1 : 2'd0;
        oIF_BP_Bypass_Sel_B  <= match_b ? slot_src_p1 : 2'd0;
        slot_vld_p1          <= slot_load_vld;
        slot_dest_p1         <= iIF_Dest_Addr;
        slot_src_p1          <= iIF_Dest_Src;
      end
    end
  end

endmodule

// File: tb/tb_cp_bypass_ctrl.sv
// Directed bench for cp_bypass_ctrl: per-cycle expectations are queued by the driver
// and checked by an independent monitor on the falling edge.
module tb_cp_bypass_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       if_valid;
  logic [4:0] addr_a;
  logic       read_a_en;
  logic [4:0] addr_b;
  logic       read_b_en;
  logic [4:0] dest_addr;
  logic       dest_en;
  logic [1:0] dest_src;
  logic       stall;
  logic       flush;

  logic        bp_read_a, bp_read_b;
  logic [1:0]  bp_sel_a, bp_sel_b;
  logic        lu_stall;
  logic [3:0]  stall_cnt;

  logic        bp_read_a2, bp_read_b2;
  logic [1:0]  bp_sel_a2, bp_sel_b2;
  logic        lu_stall2;
  logic [15:0] stall_cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        lus;
    logic        ra;
    logic [1:0]  sa;
    logic        rb;
    logic [1:0]  sb;
    logic [3:0]  cnt;
    logic        chk2;
    logic        lus2;
    logic        ra2;
    logic [1:0]  sa2;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  cp_bypass_ctrl #(.RF_INDEX_WIDTH(5), .LOAD_USE_STALL(1'b1), .CNT_WIDTH(4)) dut (
    .iClk(clk), .iReset_n(rst_n), .iIF_Valid(if_valid),
    .iIF_RF_Read_Addr_A(addr_a), .iIF_Read_A_En(read_a_en),
    .iIF_RF_Read_Addr_B(addr_b), .iIF_Read_B_En(read_b_en),
    .iIF_Dest_Addr(dest_addr), .iIF_Dest_En(dest_en), .iIF_Dest_Src(dest_src),
    .iStall(stall), .iFlush(flush),
    .oIF_BP_Bypass_Read_A(bp_read_a), .oIF_BP_Bypass_Read_B(bp_read_b),
    .oIF_BP_Bypass_Sel_A(bp_sel_a), .oIF_BP_Bypass_Sel_B(bp_sel_b),
    .oLoad_Use_Stall(lu_stall), .oStall_Count(stall_cnt)
  );

  cp_bypass_ctrl #(.RF_INDEX_WIDTH(5), .LOAD_USE_STALL(1'b0), .CNT_WIDTH(16)) dut_nostall (
    .iClk(clk), .iReset_n(rst_n), .iIF_Valid(if_valid),
    .iIF_RF_Read_Addr_A(addr_a), .iIF_Read_A_En(read_a_en),
    .iIF_RF_Read_Addr_B(addr_b), .iIF_Read_B_En(read_b_en),
    .iIF_Dest_Addr(dest_addr), .iIF_Dest_En(dest_en), .iIF_Dest_Src(dest_src),
    .iStall(stall), .iFlush(flush),
    .oIF_BP_Bypass_Read_A(bp_read_a2), .oIF_BP_Bypass_Read_B(bp_read_b2),
    .oIF_BP_Bypass_Sel_A(bp_sel_a2), .oIF_BP_Bypass_Sel_B(bp_sel_b2),
    .oLoad_Use_Stall(lu_stall2), .oStall_Count(stall_cnt2)
  );

  task automatic chk(input string name, input int row, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0d, expected %0d", name, row, act, req);
    end
  endtask

  // Monitor: registered outputs reflect the previous edge, stall reflects current inputs.
  initial begin
    int row = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        row++;
        chk("load_use_stall", row, int'(lu_stall),  int'(e.lus));
        chk("bypass_read_a",  row, int'(bp_read_a), int'(e.ra));
        chk("bypass_sel_a",   row, int'(bp_sel_a),  int'(e.sa));
        chk("bypass_read_b",  row, int'(bp_read_b), int'(e.rb));
        chk("bypass_sel_b",   row, int'(bp_sel_b),  int'(e.sb));
        chk("stall_count",    row, int'(stall_cnt), int'(e.cnt));
        if (e.chk2) begin
          chk("nostall_load_use_stall", row, int'(lu_stall2),  int'(e.lus2));
          chk("nostall_bypass_read_a",  row, int'(bp_read_a2), int'(e.ra2));
          chk("nostall_bypass_sel_a",   row, int'(bp_sel_a2),  int'(e.sa2));
          chk("nostall_stall_count",    row, int'(stall_cnt2), 0);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [4:0] ra, input logic ae,
                       input logic [4:0] rb, input logic be, input logic [4:0] d,
                       input logic de, input logic [1:0] src, input logic stl,
                       input logic fl);
    @(posedge clk);
    #1;
    if_valid  = v;  addr_a    = ra; read_a_en = ae;
    addr_b    = rb; read_b_en = be; dest_addr = d;
    dest_en   = de; dest_src  = src; stall    = stl; flush = fl;
  endtask

  task automatic exp1(input logic lus, input logic ra, input logic [1:0] sa,
                      input logic rb, input logic [1:0] sb, input logic [3:0] cnt);
    exp_t e;
    e.lus = lus; e.ra = ra; e.sa = sa; e.rb = rb; e.sb = sb; e.cnt = cnt;
    e.chk2 = 1'b0; e.lus2 = 1'b0; e.ra2 = 1'b0; e.sa2 = 2'd0;
    q.push_back(e);
  endtask

  task automatic exp2(input logic lus, input logic ra, input logic [1:0] sa,
                      input logic rb, input logic [1:0] sb, input logic [3:0] cnt,
                      input logic lus2, input logic ra2, input logic [1:0] sa2);
    exp_t e;
    e.lus = lus; e.ra = ra; e.sa = sa; e.rb = rb; e.sb = sb; e.cnt = cnt;
    e.chk2 = 1'b1; e.lus2 = lus2; e.ra2 = ra2; e.sa2 = sa2;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] cnt_exp;
    rst_n = 1'b0;
    if_valid = 1'b0; addr_a = '0; read_a_en = 1'b0; addr_b = '0; read_b_en = 1'b0;
    dest_addr = '0; dest_en = 1'b0; dest_src = 2'd0; stall = 1'b0; flush = 1'b0;

    // Reset with random inputs
    drive(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
          5'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    exp2(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 2, 1, 0, 1, 0, 0, 0);  rst_n = 1'b1;
    exp1(0, 0, 0, 0, 0, 0);

    // ALU forward on A
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);    exp1(0, 0, 0, 0, 0, 0);
    drive(1, 5, 1, 7, 1, 6, 1, 0, 0, 0);    exp1(0, 0, 0, 0, 0, 0);
    // SHADOW forward on B
    drive(1, 0, 0, 0, 0, 31, 1, 3, 0, 0);   exp1(0, 1, 0, 0, 0, 0);
    drive(1, 1, 1, 31, 1, 0, 0, 0, 0, 0);   exp1(0, 0, 0, 0, 0, 0);
    // MUL forward, same register on both ports
    drive(1, 0, 0, 0, 0, 31, 1, 1, 0, 0);   exp1(0, 0, 0, 1, 3, 0);
    drive(1, 31, 1, 31, 1, 0, 0, 0, 0, 0);  exp1(0, 0, 0, 0, 0, 0);
    // Load-use on A, compared against the no-stall variant
    drive(1, 0, 0, 0, 0, 3, 1, 2, 0, 0);    exp1(0, 1, 1, 1, 1, 0);
    drive(1, 3, 1, 9, 1, 8, 1, 0, 0, 0);    exp2(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 3, 1, 9, 1, 8, 1, 0, 0, 0);    exp2(0, 0, 0, 0, 0, 1, 0, 1, 2);
    drive(1, 8, 1, 0, 0, 10, 1, 2, 0, 0);   exp2(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // External stall for 3 cycles while a load-use hazard is pending
    for (int i = 0; i < 3; i++) begin
      drive(1, 10, 1, 0, 0, 0, 0, 0, 1, 0); exp1(1, 1, 0, 0, 0, 1);
    end
    drive(1, 10, 1, 0, 0, 0, 0, 0, 0, 0);   exp1(1, 1, 0, 0, 0, 1);
    drive(1, 10, 1, 0, 0, 12, 1, 2, 0, 0);  exp1(0, 0, 0, 0, 0, 2);
    // Flush with a load-use hazard (and stall) present
    drive(1, 12, 1, 12, 1, 14, 1, 0, 1, 1); exp1(0, 0, 0, 0, 0, 2);
    drive(1, 14, 1, 0, 0, 0, 0, 0, 0, 0);   exp1(0, 0, 0, 0, 0, 2);
    // Flush clears asserted flags and selects
    drive(1, 0, 0, 0, 0, 20, 1, 1, 0, 0);   exp1(0, 0, 0, 0, 0, 2);
    drive(1, 20, 1, 0, 0, 0, 0, 0, 0, 0);   exp1(0, 0, 0, 0, 0, 2);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);    exp1(0, 1, 1, 0, 0, 2);
    // r0 producer, disabled read, invalid IF
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);    exp1(0, 0, 0, 0, 0, 2);
    drive(1, 0, 1, 0, 1, 4, 1, 0, 0, 0);    exp1(0, 0, 0, 0, 0, 2);
    drive(1, 4, 0, 0, 0, 4, 1, 2, 0, 0);    exp1(0, 0, 0, 0, 0, 2);
    drive(0, 4, 1, 4, 1, 4, 1, 2, 0, 0);    exp1(0, 0, 0, 0, 0, 2);
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);    exp1(0, 0, 0, 0, 0, 2);

    // Back-to-back load/replay pairs drive the 4-bit counter into saturation
    cnt_exp = 4'd2;
    for (int j = 0; j < 15; j++) begin
      drive(1, 3, 1, 0, 0, 3, 1, 2, 0, 0);  exp1(0, 0, 0, 0, 0, cnt_exp);
      drive(1, 3, 1, 0, 0, 3, 1, 2, 0, 0);  exp1(1, 0, 0, 0, 0, cnt_exp);
      if (cnt_exp != 4'd15) cnt_exp = cnt_exp + 4'd1;
    end
    drive(1, 3, 1, 0, 0, 3, 1, 2, 0, 0);    exp1(0, 0, 0, 0, 0, 15);

    // Reset during a load-use stall
    drive(1, 3, 1, 0, 0, 3, 1, 2, 0, 0);    rst_n = 1'b0;
    exp1(1, 0, 0, 0, 0, 15);
    drive(1, 3, 1, 0, 0, 3, 1, 2, 0, 0);    rst_n = 1'b1;
    exp1(0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
